// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the traffic-light controller outputs.
// Rebuilds the controller phase from the sampled lamps and checks the phase
// order, the dwell lengths, the blink pattern and the red-phase countdown
// digits. The first error is latched with its code until clr_fault or reset.
module traffic_light_monitor #(
  parameter int IDLE_LEN   = 6,
  parameter int RED_LEN    = 10,
  parameter int RY_LEN     = 3,
  parameter int GREEN_LEN  = 10,
  parameter int GBLINK_LEN = 8,
  parameter int YELLOW_LEN = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       red_light,
  input  logic       yellow_light,
  input  logic       green_light,
  input  logic [6:0] seven_seg,
  input  logic       clr_fault,
  output logic [2:0] phase,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       fault,
  output logic [2:0] err_code,
  output logic [7:0] cycle_count
);

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_RED    = 3'd1,
    PH_RY     = 3'd2,
    PH_GREEN  = 3'd3,
    PH_GBLINK = 3'd4,
    PH_YELLOW = 3'd5,
    PH_FAULT  = 3'd6,
    PH_RESYNC = 3'd7
  } phase_e;

  localparam logic [4:0] L_IDLE   = 5'(IDLE_LEN);
  localparam logic [4:0] L_RED    = 5'(RED_LEN);
  localparam logic [4:0] L_RY     = 5'(RY_LEN);
  localparam logic [4:0] L_GREEN  = 5'(GREEN_LEN);
  localparam logic [4:0] L_GBLINK = 5'(GBLINK_LEN);
  localparam logic [4:0] L_YELLOW = 5'(YELLOW_LEN);

  phase_e     phase_q, phase_d;
  logic [4:0] cnt_q, cnt_d;
  logic [3:0] digit_q, digit_d;
  logic       digit_valid_q, digit_valid_d;
  logic       fault_q, fault_d;
  logic [2:0] err_code_q, err_code_d;
  logic [7:0] cycle_count_q, cycle_count_d;
  logic [2:0] prev_q, prev_d;

  logic [2:0] pat;
  logic       seg_ok;
  logic [3:0] seg_dig;
  logic       stay, leave, blink_bad;
  logic [4:0] len, idx, exp_dig;
  phase_e     nxt;
  logic [6:1] err;
  logic [2:0] code;

  assign pat = {red_light, yellow_light, green_light};

  // Decode the segment bus; anything outside the table is flagged illegal.
  always_comb begin
    seg_ok  = 1'b1;
    seg_dig = 4'd0;
    case (seven_seg)
      7'b0000000: seg_dig = 4'd0;
      7'b0000110: seg_dig = 4'd1;
      7'b1011011: seg_dig = 4'd2;
      7'b1001111: seg_dig = 4'd3;
      7'b1100110: seg_dig = 4'd4;
      7'b1101101: seg_dig = 4'd5;
      7'b1111101: seg_dig = 4'd6;
      7'b0000111: seg_dig = 4'd7;
      7'b1111111: seg_dig = 4'd8;
      7'b1101111: seg_dig = 4'd9;
      default:    seg_ok  = 1'b0;
    endcase
  end

  // Classify the sample as stay / legal exit for the current phase.
  always_comb begin
    stay      = 1'b0;
    leave     = 1'b0;
    blink_bad = 1'b0;
    len       = 5'd0;
    nxt       = phase_q;
    case (phase_q)
      PH_IDLE: begin
        len       = L_IDLE;
        stay      = (pat == 3'b000) || (pat == 3'b010);
        leave     = (pat == 3'b100);
        blink_bad = stay && (pat[1] != cnt_q[0]);
        if (leave) nxt = PH_RED;
      end
      PH_RED: begin
        len   = L_RED;
        stay  = (pat == 3'b100);
        leave = (pat == 3'b110);
        if (leave) nxt = PH_RY;
      end
      PH_RY: begin
        len   = L_RY;
        stay  = (pat == 3'b110);
        leave = (pat == 3'b001);
        if (leave) nxt = PH_GREEN;
      end
      PH_GREEN: begin
        len   = L_GREEN;
        stay  = (pat == 3'b001);
        leave = (pat == 3'b000);
        if (leave) nxt = PH_GBLINK;
      end
      PH_GBLINK: begin
        len       = L_GBLINK;
        stay      = (pat == 3'b000) || (pat == 3'b001);
        leave     = (pat == 3'b010);
        blink_bad = stay && (pat[0] != cnt_q[0]);
        if (leave) nxt = PH_YELLOW;
      end
      PH_YELLOW: begin
        len   = L_YELLOW;
        stay  = (pat == 3'b010);
        leave = (pat == 3'b100);
        if (leave) nxt = PH_RED;
      end
      default: ;
    endcase
  end

  // Gather every rule violation of this sample; lowest code wins.
  always_comb begin
    idx     = stay ? cnt_q + 5'd1 : 5'd1;
    exp_dig = L_RED - idx;
    err[1]  = !(stay || leave);
    err[2]  = leave && (cnt_q != len);
    err[3]  = stay && (cnt_q == len);
    err[4]  = blink_bad;
    err[5]  = !seg_ok;
    err[6]  = seg_ok && ((nxt == PH_RED) ? ({1'b0, seg_dig} != exp_dig)
                                         : (seven_seg != 7'd0));
    code    = 3'd0;
    for (int i = 6; i >= 1; i--)
      if (err[i]) code = 3'(i);
  end

  // Next-state: fault hold/clear, resync hunt, or normal checked tracking.
  always_comb begin
    phase_d       = phase_q;
    cnt_d         = cnt_q;
    fault_d       = fault_q;
    err_code_d    = err_code_q;
    cycle_count_d = cycle_count_q;
    prev_d        = pat;
    digit_d       = seg_ok ? seg_dig : digit_q;
    digit_valid_d = seg_ok;
    if (phase_q == PH_FAULT) begin
      if (clr_fault) begin
        phase_d    = PH_RESYNC;
        fault_d    = 1'b0;
        err_code_d = 3'd0;
      end
    end else if (phase_q == PH_RESYNC) begin
      // Only a fresh rising edge of red re-locks onto the controller.
      if (pat == 3'b100 && prev_q != 3'b100) begin
        phase_d = PH_RED;
        cnt_d   = 5'd1;
      end
    end else if (code != 3'd0) begin
      phase_d = PH_FAULT;
      fault_d = 1'b1;
      if (err_code_q == 3'd0) err_code_d = code;
    end else begin
      phase_d = nxt;
      cnt_d   = idx;
      if (phase_q == PH_YELLOW && leave && cycle_count_q != 8'hFF)
        cycle_count_d = cycle_count_q + 8'd1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase_q       <= PH_IDLE;
      cnt_q         <= 5'd0;
      digit_q       <= 4'd0;
      digit_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      err_code_q    <= 3'd0;
      cycle_count_q <= 8'd0;
      prev_q        <= 3'b000;
    end else begin
      phase_q       <= phase_d;
      cnt_q         <= cnt_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      fault_q       <= fault_d;
      err_code_q    <= err_code_d;
      cycle_count_q <= cycle_count_d;
      prev_q        <= prev_d;
    end
  end

  assign phase       = phase_q;
  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign fault       = fault_q;
  assign err_code    = err_code_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed lamp/segment sequences, a
// table-driven reference model compared every cycle, plus literal checkpoints.
module tb_traffic_light_monitor;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       red = 1'b0, yel = 1'b0, grn = 1'b0, clr = 1'b0;
  logic [6:0] seg = 7'd0;
  logic [2:0] phase, err_code;
  logic [3:0] digit;
  logic       digit_valid, fault;
  logic [7:0] cycle_count;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  traffic_light_monitor #(
    .IDLE_LEN(6), .RED_LEN(10), .RY_LEN(3), .GREEN_LEN(10), .GBLINK_LEN(8), .YELLOW_LEN(3)
  ) dut (
    .clk(clk), .resetn(resetn), .red_light(red), .yellow_light(yel), .green_light(grn),
    .seven_seg(seg), .clr_fault(clr), .phase(phase), .digit(digit),
    .digit_valid(digit_valid), .fault(fault), .err_code(err_code), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Reference tables: phase dwell lengths, exit pattern, segment codes.
  localparam int RED_LEN = 10;
  int LEN   [0:5] = '{6, 10, 3, 10, 8, 3};
  int EXITP [0:5] = '{4, 6, 1, 0, 2, 4};
  logic [6:0] seg_tab [0:9] = '{7'b0000000, 7'b0000110, 7'b1011011, 7'b1001111,
                                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                7'b1111111, 7'b1101111};

  int m_phase, m_cnt, m_digit, m_dv, m_fault, m_err, m_cc, m_prev;

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_stay(input int ph, input int p);
    case (ph)
      0: return p == 0 || p == 2;
      1: return p == 4;
      2: return p == 6;
      3: return p == 1;
      4: return p == 0 || p == 1;
      5: return p == 2;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int min_err(input int b, input int c);
    return (b == 0 || c < b) ? c : b;
  endfunction

  task automatic m_reset();
    m_phase = 0; m_cnt = 0; m_digit = 0; m_dv = 0;
    m_fault = 0; m_err = 0; m_cc = 0; m_prev = 0;
  endtask

  // Apply the observation rules to one sample.
  task automatic model_tick(input int p, input logic [6:0] s, input bit c);
    int sv, best, nph, ncnt;
    bit st, lv;
    sv = -1;
    for (int d = 0; d < 10; d++) if (seg_tab[d] == s) sv = d;
    if (sv >= 0) m_digit = sv;
    m_dv = (sv >= 0);
    if (m_phase == 6) begin
      if (c) begin m_phase = 7; m_fault = 0; m_err = 0; end
    end else if (m_phase == 7) begin
      if (p == 4 && m_prev != 4) begin m_phase = 1; m_cnt = 1; end
    end else begin
      st   = is_stay(m_phase, p);
      lv   = (p == EXITP[m_phase]);
      nph  = lv ? (m_phase == 5 ? 1 : m_phase + 1) : m_phase;
      ncnt = st ? m_cnt + 1 : 1;
      best = 0;
      if (!st && !lv) best = min_err(best, 1);
      if (lv && m_cnt != LEN[m_phase]) best = min_err(best, 2);
      if (st && m_cnt == LEN[m_phase]) best = min_err(best, 3);
      if (st && m_phase == 0 && ((p >> 1) & 1) != m_cnt % 2) best = min_err(best, 4);
      if (st && m_phase == 4 && (p & 1) != m_cnt % 2) best = min_err(best, 4);
      if (sv < 0) best = min_err(best, 5);
      else if (nph == 1 ? (sv != RED_LEN - ncnt) : (s != 7'd0)) best = min_err(best, 6);
      if (best != 0) begin
        m_phase = 6; m_fault = 1;
        if (m_err == 0) m_err = best;
      end else begin
        if (m_phase == 5 && lv && m_cc < 255) m_cc++;
        m_phase = nph; m_cnt = ncnt;
      end
    end
    m_prev = p;
  endtask

  // Every-cycle comparison of DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("phase", phase, m_phase);
      cmp("digit", digit, m_digit);
      cmp("digit_valid", digit_valid, m_dv);
      cmp("fault", fault, m_fault);
      cmp("err_code", err_code, m_err);
      cmp("cycle_count", cycle_count, m_cc);
    end
  end

  task automatic step(input logic [2:0] p, input logic [6:0] s, input logic c);
    @(negedge clk);
    {red, yel, grn} = p; seg = s; clr = c;
    @(posedge clk); #1;
    model_tick(int'(p), s, c);
  endtask

  task automatic idle_seq();
    for (int i = 0; i < 6; i++) step((i % 2) ? 3'b010 : 3'b000, 7'd0, 1'b0);
  endtask
  task automatic red_from(input int first);
    for (int i = first; i <= 10; i++) step(3'b100, seg_tab[10 - i], 1'b0);
  endtask
  task automatic ry_seq();
    repeat (3) step(3'b110, 7'd0, 1'b0);
  endtask
  task automatic green_seq(input int n);
    repeat (n) step(3'b001, 7'd0, 1'b0);
  endtask
  task automatic gblink_seq();
    for (int i = 0; i < 8; i++) step((i % 2) ? 3'b001 : 3'b000, 7'd0, 1'b0);
  endtask
  task automatic yellow_seq();
    repeat (3) step(3'b010, 7'd0, 1'b0);
  endtask
  task automatic full_cycle();
    red_from(1); ry_seq(); green_seq(10); gblink_seq(); yellow_seq();
  endtask
  // Clear the fault, then relock via 000 -> 100 (first red digit 9).
  task automatic recover();
    step(3'b000, 7'd0, 1'b1);
    step(3'b000, 7'd0, 1'b0);
    step(3'b100, seg_tab[9], 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    cmp({tag, "_phase"}, phase, 0);
    cmp({tag, "_digit"}, digit, 0);
    cmp({tag, "_dv"}, digit_valid, 0);
    cmp({tag, "_fault"}, fault, 0);
    cmp({tag, "_err"}, err_code, 0);
    cmp({tag, "_cc"}, cycle_count, 0);
  endtask

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1 check_reset_vals("reset");
    resetn = 1'b1; chk_en = 1'b1;

    // Golden: idle blink, two full cycles, then third red entry.
    idle_seq();
    cmp("idle_end_phase", phase, 0);
    full_cycle();
    full_cycle();
    step(3'b100, seg_tab[9], 1'b0);
    cmp("golden_phase", phase, 1);
    cmp("golden_cc", cycle_count, 2);
    cmp("golden_fault", fault, 0);
    cmp("golden_digit", digit, 9);

    // Red too short: 9 red samples then red+yellow.
    for (int i = 2; i <= 9; i++) step(3'b100, seg_tab[10 - i], 1'b0);
    step(3'b110, 7'd0, 1'b0);
    cmp("short_phase", phase, 6);
    cmp("short_fault", fault, 1);
    cmp("short_err", err_code, 2);

    // Green too long, then an illegal pattern must not overwrite.
    recover();
    red_from(2); ry_seq(); green_seq(10);
    step(3'b001, 7'd0, 1'b0);
    cmp("long_err", err_code, 3);
    step(3'b111, 7'b1010101, 1'b0);
    cmp("long_hold_err", err_code, 3);
    cmp("long_hold_phase", phase, 6);

    // Illegal pattern in red, alone and with a bad segment code.
    recover();
    step(3'b001, 7'd0, 1'b0);
    cmp("illegal_err", err_code, 1);
    recover();
    step(3'b001, 7'b1110000, 1'b0);
    cmp("illegal_seg_err", err_code, 1);
    cmp("illegal_seg_dv", digit_valid, 0);

    // Green blink: second sample must show green.
    recover();
    red_from(2); ry_seq(); green_seq(10);
    step(3'b000, 7'd0, 1'b0);
    step(3'b000, 7'd0, 1'b0);
    cmp("blink_err", err_code, 4);

    // Wrong countdown digit at idx 3 (8 instead of 7).
    recover();
    step(3'b100, seg_tab[8], 1'b0);
    step(3'b100, 7'b1111111, 1'b0);
    cmp("digit_err", err_code, 6);
    cmp("digit_val", digit, 8);

    // Clear, resync, relock on red.
    step(3'b100, 7'd0, 1'b1);
    cmp("clr_phase", phase, 7);
    cmp("clr_fault", fault, 0);
    cmp("clr_err", err_code, 0);
    step(3'b000, 7'd0, 1'b0);
    cmp("resync_phase", phase, 7);
    step(3'b100, seg_tab[9], 1'b0);
    cmp("relock_phase", phase, 1);
    cmp("relock_fault", fault, 0);

    // Asynchronous reset mid-green.
    red_from(2); ry_seq(); green_seq(5);
    cmp("pre_reset_phase", phase, 3);
    chk_en = 1'b0;
    #2 resetn = 1'b0;
    #1 check_reset_vals("async_reset");
    m_reset();
    {red, yel, grn} = 3'b000; seg = 7'd0; clr = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1; chk_en = 1'b1;

    // Cycle counter saturation.
    idle_seq();
    repeat (256) full_cycle();
    step(3'b100, seg_tab[9], 1'b0);
    cmp("sat_cc", cycle_count, 255);
    cmp("sat_phase", phase, 1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Receive-side checker for the traffic-light controller's output interface.
- Samples red/yellow/green and the 7-segment bus every clock and reconstructs the controller phase.
- Checks phase order, dwell lengths, blink pattern and red-phase countdown digits.
- Reports a sticky fault with first-error code. Used on-chip as a self-check and as the bench scoreboard.

Parameters:
IDLE_LEN, 6, cycles of yellow blinking after reset (even, 2..30)
RED_LEN, 10, red dwell cycles (1..10)
RY_LEN, 3, red+yellow dwell cycles (1..31)
GREEN_LEN, 10, green dwell cycles (1..31)
GBLINK_LEN, 8, green-blink dwell cycles (even, 2..30)
YELLOW_LEN, 3, yellow dwell cycles (1..31)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
red_light  in  1  observed red
yellow_light  in  1  observed yellow
green_light  in  1  observed green
seven_seg  in  7  observed segment bus
clr_fault  in  1  synchronous fault clear, one-cycle pulse
phase  out  3  0 IDLE, 1 RED, 2 RED_YELLOW, 3 GREEN, 4 GREEN_BLINK, 5 YELLOW, 6 FAULT, 7 RESYNC
digit  out  4  decoded digit of last sample
digit_valid  out  1  last sample was a legal segment pattern
fault  out  1  sticky error flag
err_code  out  3  first error since reset/clear
cycle_count  out  8  completed YELLOW->RED transitions, saturating at 255

Behaviour:
- Reset values: phase=0, dwell cnt=0, digit=0, digit_valid=0, fault=0, err_code=0, cycle_count=0. Reset is asynchronous and takes effect immediately, including mid-phase.
- All outputs are registered. The result for the pattern sampled at edge N is visible after edge N (one-cycle latency).
- Pattern P = {R,Y,G}.
- Segment table:
  - 0 = 0000000, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111
  - Any other pattern: digit_valid=0, digit holds its previous value.
- Transition table (anything else in phases 0-5 is err 1):
  - IDLE: 000/010 stay; 100 -> RED.
  - RED: 100 stay; 110 -> RED_YELLOW.
  - RED_YELLOW: 110 stay; 001 -> GREEN.
  - GREEN: 001 stay; 000 -> GREEN_BLINK.
  - GREEN_BLINK: 000/001 stay; 010 -> YELLOW.
  - YELLOW: 010 stay; 100 -> RED, and cycle_count+1.
- Dwell counter: 5 bits.
  - Entering a phase sets cnt=1. Reset leaves IDLE with cnt=0.
  - Each stay increments cnt.
  - Stay sample while cnt==LEN: err 3 (too long).
  - Leave while cnt!=LEN: err 2 (too short).
- Blink rule: on a stay sample in IDLE (yellow) or GREEN_BLINK (green), the blinking light must equal cnt[0] (pre-increment value). Otherwise err 4.
- Countdown rule:
  - In RED, with idx the post-update cnt, the sampled digit must equal RED_LEN-idx (9 down to 0 at default). Otherwise err 6.
  - In every other checked phase, seven_seg must be 0000000. Otherwise err 6.
  - An illegal segment pattern in phases 0-5 is err 5.
- Error handling:
  - Multiple errors on the same sample: lowest code wins.
  - Any error: phase<=FAULT, fault<=1. err_code is written only if it is currently 0.
  - FAULT ignores inputs. cycle_count freezes.
- clr_fault:
  - In FAULT: phase<=RESYNC, fault<=0, err_code<=0.
  - clr_fault outside FAULT has no effect.
- RESYNC: no checks. The first sample of 100 whose previous sample was not 100 -> RED with cnt=1, and checking resumes.
- A previous-pattern register is kept for RESYNC only. It resets to 000.

Test Plan:
- Golden sequence from reset for two full cycles (6 idle 0/1 blink, red 10 with digits 9..0, RY 3, green 10, blink 8 starting 0, yellow 3) -> phase 0,1,2,3,4,5,1,... with fault=0, cycle_count=2.
- Red held 9 cycles then 110 -> one cycle after the 110 sample: phase=6, fault=1, err_code=2.
- Green held for an 11th sample -> fault after that sample, err_code=3. A further illegal pattern leaves err_code=3.
- In RED present 001 -> err_code=1. Same sample also showing an illegal segment pattern -> still err_code=1.
- GREEN_BLINK second sample with green=0 -> err_code=4.
- RED idx 3 with segments 1111111 (8 instead of 7) -> err_code=6.
  - Then pulse clr_fault and drive 000, 100 -> phase 7 then 1, fault=0.
  - Then assert resetn=0 mid-GREEN -> all outputs at reset values before the next clock edge.
